axi_native_wr_bridge: RTL and testbench
=======================================

AXI_NATIVE_WR_BRIDGE -- requirements
Module: axi_native_wr_bridge

Interface
REQ-001 SHALL have parameter NATIVE_AW, default 26: native command address width.
REQ-002 SHALL have parameter BRESP_DEPTH, default 4: B-response queue depth, power of two.
REQ-003 SHALL have port clk, input, 1: sole clock, all logic on posedge.
REQ-004 SHALL have port rst, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port aw_valid, input, 1: AW request valid.
REQ-006 SHALL have port aw_ready, output, 1: AW accepted.
REQ-007 SHALL have port aw_addr, input, 32: byte address.
REQ-008 SHALL have port aw_burst, input, 2: 0 FIXED, 1 INCR, 2 WRAP, 3 reserved.
REQ-009 SHALL have port aw_len, input, 8: beats minus one.
REQ-010 SHALL have port aw_id, input, 1: transaction ID.
REQ-011 SHALL have port w_valid, input, 1: write beat valid.
REQ-012 SHALL have port w_ready, output, 1: write beat accepted.
REQ-013 SHALL have port w_last, input, 1: master's last-beat flag.
REQ-014 SHALL have port w_data, input, 256: beat data.
REQ-015 SHALL have port w_strb, input, 32: byte enables.
REQ-016 SHALL have port b_valid, output, 1: response valid.
REQ-017 SHALL have port b_ready, input, 1: response accepted.
REQ-018 SHALL have port b_resp, output, 2: 2'b00 OKAY, 2'b10 SLVERR.
REQ-019 SHALL have port b_id, output, 1: echoed aw_id.
REQ-020 SHALL have port native_cmd_valid, output, 1: native command valid.
REQ-021 SHALL have port native_cmd_ready, input, 1: native command accepted.
REQ-022 SHALL have port native_cmd_payload_we, output, 1: constant 1 while valid.
REQ-023 SHALL have port native_cmd_payload_mw, output, 1: masked write (strobe not all ones).
REQ-024 SHALL have port native_cmd_payload_addr, output, NATIVE_AW: beat address, aw_addr[NATIVE_AW+4:5] stepped per beat.
REQ-025 SHALL have port wdata_valid, output, 1: native write data valid.
REQ-026 SHALL have port wdata_ready, input, 1: native write data accepted.
REQ-027 SHALL have port wdata_payload_data, output, 256: pass-through of w_data.
REQ-028 SHALL have port wdata_payload_we, output, 32: pass-through of w_strb.

Function
REQ-029 FSM states SHALL be IDLE, CMD, DATA, DRAIN; aw_ready=1 only in IDLE with queue count < BRESP_DEPTH.
REQ-030 AW handshake in cycle t SHALL latch addr/len/burst/id and enter CMD (native_cmd_valid=1 at t+1), or DRAIN for burst 3.
REQ-031 In CMD, native_cmd_valid SHALL hold with stable payload until native_cmd_ready; mw = ~&w_strb of the pending beat, evaluated when w_valid=1; cmd_valid SHALL wait for w_valid.
REQ-032 In DATA, wdata_valid=w_valid, w_ready=wdata_ready, payload combinational pass-through; beat completes on w handshake.
REQ-033 After each beat the bridge SHALL return to CMD, or on beat counter == len push {id,resp} to the queue and go IDLE.
REQ-034 Address stepping SHALL be: FIXED hold; INCR +1 modulo 2^NATIVE_AW; WRAP +1 within an aligned window of len+1 beats.
REQ-035 The beat counter SHALL be authoritative; w_last asserted early or missing on the final beat SHALL set resp SLVERR without changing beat count.
REQ-036 DRAIN SHALL assert w_ready=1, issue no native traffic, consume len+1 beats, then push SLVERR.
REQ-037 b_valid = queue non-empty; simultaneous push and pop SHALL leave count unchanged; push when full SHALL be impossible by REQ-029.

Reset
REQ-038 With rst=0, all valid/ready outputs, b_resp, b_id, native address, counter and queue SHALL be 0, state IDLE; reset mid-burst SHALL abort it with no response.

Configuration
REQ-039 With AXI_WR_WRAP_EN defined, WRAP SHALL follow REQ-034; without it, burst 2 SHALL be handled as burst 3 (DRAIN, SLVERR).

Structure
REQ-040 Package axi_wr_pkg SHALL hold the burst enum, RESP_OKAY/RESP_SLVERR, the FSM state enum and BEAT_BYTES=32.
REQ-041 The response queue SHALL be sub-module axi_wr_bresp_fifo.

Verification
REQ-042 INCR aw_addr=0x1000, len=3, strb all ones -> native addrs 0x80..0x83, mw=0, one OKAY with id echoed.
REQ-043 WRAP (macro on) aw_addr=0x1060, len=3 -> addrs 0x83,0x80,0x81,0x82; macro off -> 4 beats drained, SLVERR.
REQ-044 burst=3, len=1 -> 2 beats drained, no native_cmd_valid, SLVERR.
REQ-045 b_ready=0, five single-beat bursts -> fourth accepted, fifth aw_ready=0 until one B pops.
REQ-046 len=1, w_last on beat 0 -> two native beats, SLVERR; strb 0x0000FFFF -> mw=1.

Source files
------------

// File: rtl/axi_wr_pkg.sv
// rtl/axi_wr_pkg.sv - shared burst, response and FSM definitions for the AXI write bridge
package axi_wr_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CMD   = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef enum logic [1:0] {
    FSM_IDLE  = ST_IDLE,
    FSM_CMD   = ST_CMD,
    FSM_DATA  = ST_DATA,
    FSM_DRAIN = ST_DRAIN
  } fsm_state_e;

  localparam int BEAT_BYTES = 32;

endpackage

// File: rtl/axi_wr_bresp_fifo.sv
// rtl/axi_wr_bresp_fifo.sv - B-response queue holding {id, resp}; DEPTH must be a power of two >= 2
module axi_wr_bresp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             not_empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_pop;

  assign do_pop    = pop && (count != '0);
  assign not_empty = (count != '0);
  assign full      = (count == (PW+1)'(DEPTH));
  assign pop_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_native_wr_bridge.sv
// rtl/axi_native_wr_bridge.sv - AXI write bursts to native cmd/data beats; WRAP bursts enabled by AXI_WR_WRAP_EN
module axi_native_wr_bridge
  import axi_wr_pkg::*;
#(
  parameter int NATIVE_AW   = 26,
  parameter int BRESP_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 aw_valid,
  output logic                 aw_ready,
  input  logic [31:0]          aw_addr,
  input  logic [1:0]           aw_burst,
  input  logic [7:0]           aw_len,
  input  logic                 aw_id,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic                 w_last,
  input  logic [255:0]         w_data,
  input  logic [31:0]          w_strb,
  output logic                 b_valid,
  input  logic                 b_ready,
  output logic [1:0]           b_resp,
  output logic                 b_id,
  output logic                 native_cmd_valid,
  input  logic                 native_cmd_ready,
  output logic                 native_cmd_payload_we,
  output logic                 native_cmd_payload_mw,
  output logic [NATIVE_AW-1:0] native_cmd_payload_addr,
  output logic                 wdata_valid,
  input  logic                 wdata_ready,
  output logic [255:0]         wdata_payload_data,
  output logic [31:0]          wdata_payload_we
);

  logic [1:0]           state;
  logic [NATIVE_AW-1:0] addr_q;
  logic [NATIVE_AW-1:0] addr_next;
  logic [7:0]           len_q;
  logic [7:0]           cnt_q;
  logic [1:0]           burst_q;
  logic                 id_q;
  logic                 err_q;
  logic                 aw_hs;
  logic                 w_hs;
  logic                 last_beat;
  logic                 last_bad;
  logic                 drain_burst;
  logic                 q_push;
  logic [2:0]           q_push_data;
  logic [2:0]           q_pop_data;
  logic                 q_not_empty;
  logic                 q_full;
  logic                 unused_addr_bits;

  // Byte offset and bits above the native window never reach the native side.
  assign unused_addr_bits = ^aw_addr;

  assign aw_ready = rst && (state == ST_IDLE) && !q_full;
  assign aw_hs    = aw_valid && aw_ready;

  assign native_cmd_valid        = (state == ST_CMD) && w_valid;
  assign native_cmd_payload_we   = native_cmd_valid;
  assign native_cmd_payload_mw   = native_cmd_valid && !(&w_strb);
  assign native_cmd_payload_addr = addr_q;

  assign wdata_valid        = (state == ST_DATA) && w_valid;
  assign wdata_payload_data = w_data;
  assign wdata_payload_we   = w_strb;

  assign w_ready   = ((state == ST_DATA) && wdata_ready) || (state == ST_DRAIN);
  assign w_hs      = w_valid && w_ready;
  assign last_beat = (cnt_q == len_q);
  assign last_bad  = (w_last != last_beat);

`ifdef AXI_WR_WRAP_EN
  logic [NATIVE_AW-1:0] wrap_mask;
  assign wrap_mask   = NATIVE_AW'(len_q);
  assign drain_burst = (aw_burst == BURST_RSVD);
`else
  assign drain_burst = (aw_burst == BURST_RSVD) || (aw_burst == BURST_WRAP);
`endif

  always_comb begin
    addr_next = addr_q;
    case (burst_q)
      BURST_INCR: addr_next = addr_q + 1'b1;
`ifdef AXI_WR_WRAP_EN
      // Wrap windows are len+1 beats, always a power of two for legal bursts.
      BURST_WRAP: addr_next = (addr_q & ~wrap_mask) | ((addr_q + 1'b1) & wrap_mask);
`endif
      default:    addr_next = addr_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      burst_q <= '0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (aw_hs) begin
          addr_q  <= aw_addr[NATIVE_AW+4:5];
          len_q   <= aw_len;
          burst_q <= aw_burst;
          id_q    <= aw_id;
          cnt_q   <= '0;
          err_q   <= 1'b0;
          state   <= drain_burst ? ST_DRAIN : ST_CMD;
        end
        ST_CMD: if (native_cmd_valid && native_cmd_ready) state <= ST_DATA;
        ST_DATA: if (w_hs) begin
          if (last_bad) err_q <= 1'b1;
          if (last_beat) begin
            state <= ST_IDLE;
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            addr_q <= addr_next;
            state  <= ST_CMD;
          end
        end
        ST_DRAIN: if (w_hs) begin
          if (last_beat) state <= ST_IDLE;
          else           cnt_q <= cnt_q + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // w_ready is only high in DATA/DRAIN, so a final-beat handshake always ends a burst.
  assign q_push      = w_hs && last_beat;
  assign q_push_data = {id_q, ((state == ST_DRAIN) || err_q || last_bad) ? RESP_SLVERR : RESP_OKAY};

  axi_wr_bresp_fifo #(
    .DEPTH (BRESP_DEPTH),
    .WIDTH (3)
  ) u_bresp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (b_ready),
    .pop_data  (q_pop_data),
    .not_empty (q_not_empty),
    .full      (q_full)
  );

  assign b_valid = q_not_empty;
  assign b_resp  = q_pop_data[1:0];
  assign b_id    = q_pop_data[2];

endmodule

// File: tb/tb_axi_native_wr_bridge.sv
// tb/tb_axi_native_wr_bridge.sv - randomized self-checking bench for axi_native_wr_bridge
module tb_axi_native_wr_bridge;

  localparam int NATIVE_AW   = 26;
  localparam int BRESP_DEPTH = 4;
`ifdef AXI_WR_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 aw_valid = 1'b0;
  logic                 aw_ready;
  logic [31:0]          aw_addr = '0;
  logic [1:0]           aw_burst = '0;
  logic [7:0]           aw_len = '0;
  logic                 aw_id = 1'b0;
  logic                 w_valid = 1'b0;
  logic                 w_ready;
  logic                 w_last = 1'b0;
  logic [255:0]         w_data = '0;
  logic [31:0]          w_strb = '0;
  logic                 b_valid;
  logic                 b_ready = 1'b1;
  logic [1:0]           b_resp;
  logic                 b_id;
  logic                 native_cmd_valid;
  logic                 native_cmd_ready = 1'b1;
  logic                 native_cmd_payload_we;
  logic                 native_cmd_payload_mw;
  logic [NATIVE_AW-1:0] native_cmd_payload_addr;
  logic                 wdata_valid;
  logic                 wdata_ready = 1'b1;
  logic [255:0]         wdata_payload_data;
  logic [31:0]          wdata_payload_we;

  always #5 clk = ~clk;

  axi_native_wr_bridge #(.NATIVE_AW(NATIVE_AW), .BRESP_DEPTH(BRESP_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_burst(aw_burst),
    .aw_len(aw_len), .aw_id(aw_id),
    .w_valid(w_valid), .w_ready(w_ready), .w_last(w_last), .w_data(w_data), .w_strb(w_strb),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp), .b_id(b_id),
    .native_cmd_valid(native_cmd_valid), .native_cmd_ready(native_cmd_ready),
    .native_cmd_payload_we(native_cmd_payload_we), .native_cmd_payload_mw(native_cmd_payload_mw),
    .native_cmd_payload_addr(native_cmd_payload_addr),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .wdata_payload_data(wdata_payload_data), .wdata_payload_we(wdata_payload_we)
  );

  typedef struct packed { logic [NATIVE_AW-1:0] addr; logic mw; } cmd_t;
  typedef struct packed { logic [255:0] data; logic [31:0] strb; } dat_t;
  typedef struct packed { logic id; logic [1:0] resp; } b_t;

  cmd_t got_cmd[$];
  cmd_t exp_cmd[$];
  dat_t got_dat[$];
  dat_t exp_dat[$];
  b_t   got_b[$];
  b_t   exp_b[$];

  int vectors = 0;
  int miscompares = 0;
  bit rand_rdy = 1'b0;

  // Handshake monitor, sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (rst) begin
      if (native_cmd_valid && native_cmd_ready)
        got_cmd.push_back('{native_cmd_payload_addr, native_cmd_payload_mw});
      if (wdata_valid && wdata_ready)
        got_dat.push_back('{wdata_payload_data, wdata_payload_we});
      if (b_valid && b_ready)
        got_b.push_back('{b_id, b_resp});
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) begin
        native_cmd_ready = 1'($urandom_range(0, 1));
        wdata_ready      = 1'($urandom_range(0, 1));
      end else begin
        native_cmd_ready = 1'b1;
        wdata_ready      = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_q();
    got_cmd.delete(); exp_cmd.delete();
    got_dat.delete(); exp_dat.delete();
    got_b.delete();   exp_b.delete();
  endtask

  task automatic wait_b(input int n);
    for (int t = 0; t < 100 && got_b.size() < n; t++) tick();
  endtask

  // Drives one burst and records what an ideal bridge must produce for it.
  // strb_mode: 0 all ones, 1 low half, 2 random; last_at: beat index carrying w_last.
  task automatic send_burst(input logic [31:0] addr, input logic [1:0] burst, input logic [7:0] len,
                            input logic id, input int strb_mode, input int last_at);
    bit drain;
    bit err;
    logic [63:0] bb, lo, a, n;
    logic [255:0] d;
    logic [31:0] s;
    drain = (burst == 2'd3) || (burst == 2'd2 && !WRAP_EN);
    err   = drain;
    bb    = 64'(addr[NATIVE_AW+4:5]);
    n     = 64'(len) + 64'd1;
    aw_addr = addr; aw_burst = burst; aw_len = len; aw_id = id; aw_valid = 1'b1;
    for (int t = 0; t < 200 && !aw_ready; t++) tick();
    if (!aw_ready) begin
      vectors++; miscompares++;
      $display("FAIL aw_timeout: aw_ready=%0b required 1", aw_ready);
    end
    tick();
    aw_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom();
      s = (strb_mode == 0) ? 32'hFFFF_FFFF : (strb_mode == 1) ? 32'h0000_FFFF : $urandom();
      if ((i == last_at) != (i == int'(len))) err = 1'b1;
      if (!drain) begin
        case (burst)
          2'd0:    a = bb;
          2'd1:    a = (bb + 64'(i)) % (64'd1 << NATIVE_AW);
          default: begin
            lo = (bb / n) * n;
            a  = lo + ((bb - lo + 64'(i)) % n);
          end
        endcase
        exp_cmd.push_back('{a[NATIVE_AW-1:0], (s != 32'hFFFF_FFFF)});
        exp_dat.push_back('{d, s});
      end
      w_valid = 1'b1; w_data = d; w_strb = s; w_last = (i == last_at);
      for (int t = 0; t < 200 && !w_ready; t++) tick();
      if (!w_ready) begin
        vectors++; miscompares++;
        $display("FAIL w_timeout: beat %0d w_ready=%0b required 1", i, w_ready);
        break;
      end
      tick();
    end
    w_valid = 1'b0; w_last = 1'b0;
    exp_b.push_back('{id, err ? 2'b10 : 2'b00});
  endtask

  task automatic test_reset();
    rst = 1'b0; aw_valid = 1'b1; w_valid = 1'b1; w_strb = '1;
    tick();
    vectors += 8;
    if (aw_ready !== 1'b0) begin miscompares++; $display("FAIL rst_aw_ready: got %0b want 0", aw_ready); end
    if (w_ready !== 1'b0) begin miscompares++; $display("FAIL rst_w_ready: got %0b want 0", w_ready); end
    if (b_valid !== 1'b0) begin miscompares++; $display("FAIL rst_b_valid: got %0b want 0", b_valid); end
    if (native_cmd_valid !== 1'b0) begin miscompares++; $display("FAIL rst_cmd_valid: got %0b want 0", native_cmd_valid); end
    if (wdata_valid !== 1'b0) begin miscompares++; $display("FAIL rst_wdata_valid: got %0b want 0", wdata_valid); end
    if (b_resp !== 2'b00) begin miscompares++; $display("FAIL rst_b_resp: got %0h want 0", b_resp); end
    if (b_id !== 1'b0) begin miscompares++; $display("FAIL rst_b_id: got %0b want 0", b_id); end
    if (native_cmd_payload_addr !== '0) begin miscompares++; $display("FAIL rst_addr: got %0h want 0", native_cmd_payload_addr); end
    aw_valid = 1'b0; w_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    vectors++;
    if (aw_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_aw_ready: got %0b want 1", aw_ready); end
  endtask

  task automatic test_incr();
    clear_q();
    send_burst(32'h1000, 2'd1, 8'd3, 1'b1, 0, 3);
    wait_b(1);
    vectors++;
    if (got_cmd.size() != 4) begin miscompares++; $display("FAIL incr_cmd_count: got %0d want 4", got_cmd.size()); end
    for (int i = 0; i < 4 && i < got_cmd.size(); i++) begin
      vectors += 2;
      if (got_cmd[i].addr !== NATIVE_AW'(32'h80 + i)) begin miscompares++; $display("FAIL incr_addr[%0d]: got %0h want %0h", i, got_cmd[i].addr, 32'h80 + i); end
      if (got_cmd[i].mw !== 1'b0) begin miscompares++; $display("FAIL incr_mw[%0d]: got %0b want 0", i, got_cmd[i].mw); end
    end
    for (int i = 0; i < 4 && i < got_dat.size(); i++) begin
      vectors++;
      if (got_dat[i] !== exp_dat[i]) begin miscompares++; $display("FAIL incr_data[%0d]: got %0h want %0h", i, got_dat[i].strb, exp_dat[i].strb); end
    end
    vectors++;
    if (got_b.size() != 1 || got_b[0] !== 3'b100) begin
      miscompares++; $display("FAIL incr_bresp: got count %0d value %0h want 1 of 4", got_b.size(), got_b.size() ? got_b[0] : 3'b0);
    end
  endtask

  task automatic test_wrap();
    logic [NATIVE_AW-1:0] want [4];
    want[0] = 'h83; want[1] = 'h80; want[2] = 'h81; want[3] = 'h82;
    clear_q();
    send_burst(32'h1060, 2'd2, 8'd3, 1'b0, 0, 3);
    wait_b(1);
    vectors += 2;
    if (got_cmd.size() != (WRAP_EN ? 4 : 0)) begin miscompares++; $display("FAIL wrap_cmd_count: got %0d want %0d", got_cmd.size(), WRAP_EN ? 4 : 0); end
    if (got_b.size() != 1 || got_b[0].resp !== (WRAP_EN ? 2'b00 : 2'b10)) begin
      miscompares++; $display("FAIL wrap_bresp: got count %0d resp %0h want %0h", got_b.size(), got_b.size() ? got_b[0].resp : 2'b0, WRAP_EN ? 2'b00 : 2'b10);
    end
    for (int i = 0; i < got_cmd.size() && i < 4; i++) begin
      vectors++;
      if (got_cmd[i].addr !== want[i]) begin miscompares++; $display("FAIL wrap_addr[%0d]: got %0h want %0h", i, got_cmd[i].addr, want[i]); end
    end
  endtask

  task automatic test_reserved();
    clear_q();
    send_burst(32'h2000, 2'd3, 8'd1, 1'b1, 2, 1);
    wait_b(1);
    vectors += 3;
    if (got_cmd.size() != 0) begin miscompares++; $display("FAIL rsvd_cmd_count: got %0d want 0", got_cmd.size()); end
    if (got_dat.size() != 0) begin miscompares++; $display("FAIL rsvd_dat_count: got %0d want 0", got_dat.size()); end
    if (got_b.size() != 1 || got_b[0] !== 3'b110) begin
      miscompares++; $display("FAIL rsvd_bresp: got count %0d value %0h want 1 of 6", got_b.size(), got_b.size() ? got_b[0] : 3'b0);
    end
  endtask

  task automatic test_wlast_err();
    clear_q();
    send_burst(32'h4000, 2'd1, 8'd1, 1'b0, 1, 0);
    wait_b(1);
    vectors += 2;
    if (got_cmd.size() != 2) begin miscompares++; $display("FAIL wlast_cmd_count: got %0d want 2", got_cmd.size()); end
    if (got_b.size() != 1 || got_b[0] !== 3'b010) begin
      miscompares++; $display("FAIL wlast_bresp: got count %0d value %0h want 1 of 2", got_b.size(), got_b.size() ? got_b[0] : 3'b0);
    end
    for (int i = 0; i < got_cmd.size(); i++) begin
      vectors++;
      if (got_cmd[i].mw !== 1'b1) begin miscompares++; $display("FAIL wlast_mw[%0d]: got %0b want 1", i, got_cmd[i].mw); end
    end
  endtask

  task automatic test_bqueue_full();
    clear_q();
    b_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_burst(32'(k * 32), 2'd1, 8'd0, 1'(k), 0, 0);
    tick(); tick();
    vectors += 2;
    if (b_valid !== 1'b1) begin miscompares++; $display("FAIL full_b_valid: got %0b want 1", b_valid); end
    if (aw_ready !== 1'b0) begin miscompares++; $display("FAIL full_aw_ready: got %0b want 0", aw_ready); end
    for (int t = 0; t < 3; t++) begin
      tick();
      vectors++;
      if (aw_ready !== 1'b0) begin miscompares++; $display("FAIL full_aw_hold[%0d]: got %0b want 0", t, aw_ready); end
    end
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    vectors += 2;
    if (aw_ready !== 1'b1) begin miscompares++; $display("FAIL after_pop_aw_ready: got %0b want 1", aw_ready); end
    if (got_b.size() != 1) begin miscompares++; $display("FAIL after_pop_count: got %0d want 1", got_b.size()); end
    send_burst(32'h200, 2'd1, 8'd0, 1'b0, 0, 0);
    b_ready = 1'b1;
    wait_b(5);
    vectors++;
    if (got_b.size() != 5) begin miscompares++; $display("FAIL full_b_count: got %0d want 5", got_b.size()); end
    for (int i = 0; i < got_b.size() && i < 5; i++) begin
      vectors++;
      if (got_b[i] !== {(i == 4) ? 1'b0 : 1'(i), 2'b00}) begin
        miscompares++; $display("FAIL full_b[%0d]: got %0h want id %0d okay", i, got_b[i], (i == 4) ? 0 : i % 2);
      end
    end
  endtask

  task automatic test_reset_midburst();
    clear_q();
    aw_addr = 32'h3000; aw_burst = 2'd1; aw_len = 8'd3; aw_id = 1'b1; aw_valid = 1'b1;
    for (int t = 0; t < 20 && !aw_ready; t++) tick();
    tick();
    aw_valid = 1'b0;
    w_valid = 1'b1; w_strb = '1; w_data = '1; w_last = 1'b0;
    for (int t = 0; t < 20 && !w_ready; t++) tick();
    tick();
    w_valid = 1'b0;
    rst = 1'b0;
    tick();
    vectors += 2;
    if (native_cmd_valid !== 1'b0 || w_ready !== 1'b0) begin
      miscompares++; $display("FAIL midrst_outputs: cmd_valid=%0b w_ready=%0b want 0 0", native_cmd_valid, w_ready);
    end
    if (aw_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_aw_ready: got %0b want 0", aw_ready); end
    rst = 1'b1;
    for (int t = 0; t < 5; t++) tick();
    vectors += 3;
    if (b_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_b_valid: got %0b want 0", b_valid); end
    if (got_b.size() != 0) begin miscompares++; $display("FAIL midrst_b_count: got %0d want 0", got_b.size()); end
    if (aw_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_aw_ready_after: got %0b want 1", aw_ready); end
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [1:0]  burst;
    logic [7:0]  len;
    int          last_at;
    clear_q();
    rand_rdy = 1'b1;
    for (int k = 0; k < 30; k++) begin
      addr  = $urandom();
      if ($urandom_range(0, 4) == 0) addr = addr | 32'h7FFF_FFE0;
      burst = 2'($urandom_range(0, 3));
      len   = (burst == 2'd2) ? 8'((1 << $urandom_range(0, 3)) - 1) : 8'($urandom_range(0, 7));
      last_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, int'(len) + 1) : int'(len);
      send_burst(addr, burst, len, 1'($urandom_range(0, 1)), $urandom_range(0, 2), last_at);
    end
    wait_b(exp_b.size());
    rand_rdy = 1'b0;
    vectors += 3;
    if (got_cmd.size() != exp_cmd.size()) begin miscompares++; $display("FAIL rnd_cmd_count: got %0d want %0d", got_cmd.size(), exp_cmd.size()); end
    if (got_dat.size() != exp_dat.size()) begin miscompares++; $display("FAIL rnd_dat_count: got %0d want %0d", got_dat.size(), exp_dat.size()); end
    if (got_b.size() != exp_b.size()) begin miscompares++; $display("FAIL rnd_b_count: got %0d want %0d", got_b.size(), exp_b.size()); end
    for (int i = 0; i < got_cmd.size() && i < exp_cmd.size(); i++) begin
      vectors++;
      if (got_cmd[i] !== exp_cmd[i]) begin
        miscompares++; $display("FAIL rnd_cmd[%0d]: got addr %0h mw %0b want addr %0h mw %0b", i, got_cmd[i].addr, got_cmd[i].mw, exp_cmd[i].addr, exp_cmd[i].mw);
      end
    end
    for (int i = 0; i < got_dat.size() && i < exp_dat.size(); i++) begin
      vectors++;
      if (got_dat[i] !== exp_dat[i]) begin
        miscompares++; $display("FAIL rnd_dat[%0d]: got strb %0h data %0h want strb %0h data %0h", i, got_dat[i].strb, got_dat[i].data[31:0], exp_dat[i].strb, exp_dat[i].data[31:0]);
      end
    end
    for (int i = 0; i < got_b.size() && i < exp_b.size(); i++) begin
      vectors++;
      if (got_b[i] !== exp_b[i]) begin
        miscompares++; $display("FAIL rnd_b[%0d]: got id %0b resp %0h want id %0b resp %0h", i, got_b[i].id, got_b[i].resp, exp_b[i].id, exp_b[i].resp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_reserved();
    test_wlast_err();
    test_bqueue_full();
    test_reset_midburst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
